// File: rtl/cart_sram_arbiter_if.sv
// Bus bundle between the cart/host side and the save-SRAM arbiter.
// slave = arbiter view, master = surrounding logic / bench view.
interface cart_sram_arbiter_if;
    logic        cart_ram_sel;
    logic [3:0]  cart_bank;
    logic [12:0] cart_a;
    logic        cart_nCS;
    logic        cart_nRD;
    logic        cart_nWR;
    logic        cart_wren;
    logic [7:0]  cart_wdata;
    logic [7:0]  cart_rdata;
    logic        host_req;
    logic        host_we;
    logic [16:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        host_busy;
    logic [7:0]  abort_count;
    logic [16:0] sram_a;
    logic [7:0]  sram_dq_i;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_nCE;
    logic        sram_nOE;
    logic        sram_nWE;

    modport slave (
        input  cart_ram_sel, cart_bank, cart_a, cart_nCS, cart_nRD, cart_nWR,
               cart_wren, cart_wdata, host_req, host_we, host_addr, host_wdata,
               sram_dq_i,
        output cart_rdata, host_rdata, host_ack, host_busy, abort_count,
               sram_a, sram_dq_o, sram_dq_oe, sram_nCE, sram_nOE, sram_nWE
    );

    modport master (
        output cart_ram_sel, cart_bank, cart_a, cart_nCS, cart_nRD, cart_nWR,
               cart_wren, cart_wdata, host_req, host_we, host_addr, host_wdata,
               sram_dq_i,
        input  cart_rdata, host_rdata, host_ack, host_busy, abort_count,
               sram_a, sram_dq_o, sram_dq_oe, sram_nCE, sram_nOE, sram_nWE
    );
endinterface

// File: rtl/cart_sram_arbiter.sv
// Save-SRAM arbiter: cart bus passes through with priority, host accesses
// are squeezed into cart idle gaps and aborted/retried on cart activity.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | cart owns the pins; waits for host request and idle gap
//  S_SETUP  | host owns pins, address/data settle before the strobe
//  S_STROBE | host nOE (read) or nWE (write) asserted
//  S_HOLD   | strobe released, address/data held
//  S_ACK    | cart owns pins again, one-cycle host_ack pulse
module cart_sram_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_GAP    = 4,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1
) (
    input  logic               sys_clock,
    input  logic               sys_resetn,
    cart_sram_arbiter_if.slave bus
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [3:0]       IDLE_MAX  = 4'(IDLE_GAP);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_idle_cnt;
    logic [16:0]            r_addr;
    logic                   r_we;
    logic [7:0]             r_wdata;
    logic [7:0]             r_rdata;
    logic [7:0]             r_abort_cnt;
    logic                   r_ack;
    logic                   r_busy;

    logic        w_cart_busy_raw;
    logic        w_cart_busy_s;
    logic        w_host_go;
    logic        w_tc;
    logic        w_host_phase;
    logic        w_owner_host;
    logic        w_cart_nce;
    logic [16:0] w_sram_a;
    logic [7:0]  w_dq_o;
    logic        w_dq_oe;
    logic        w_nce;
    logic        w_noe;
    logic        w_nwe;

    assign w_cart_busy_raw = ~bus.cart_nCS | ~bus.cart_nRD | ~bus.cart_nWR;
    assign w_cart_busy_s   = r_sync[SYNC_STAGES-1];

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_sync     <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(w_cart_busy_raw);
            if (w_cart_busy_s)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != IDLE_MAX)
                r_idle_cnt <= r_idle_cnt + 4'd1;
        end
    end

    // r_busy doubles as the retry flag so an aborted access restarts without host_req.
    assign w_host_go = (bus.host_req | r_busy) & (r_idle_cnt == IDLE_MAX) & ~w_cart_busy_s;
    assign w_tc      = (r_cnt == '0);

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_abort_cnt <= '0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_host_go) begin
                        r_state <= S_SETUP;
                        r_cnt   <= SETUP_LD;
                        r_busy  <= 1'b1;
                        if (!r_busy) begin
                            r_addr  <= bus.host_addr;
                            r_we    <= bus.host_we;
                            r_wdata <= bus.host_wdata;
                        end
                    end
                end
                S_SETUP, S_STROBE, S_HOLD: begin
                    if (w_cart_busy_s) begin
                        r_state <= S_IDLE;
                        if (r_abort_cnt != 8'hFF)
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                    end else if (w_tc) begin
                        case (r_state)
                            S_SETUP: begin
                                r_state <= S_STROBE;
                                r_cnt   <= STROBE_LD;
                            end
                            S_STROBE: begin
                                r_state <= S_HOLD;
                                r_cnt   <= HOLD_LD;
                                if (!r_we)
                                    r_rdata <= bus.sram_dq_i;
                            end
                            default: begin
                                r_state <= S_ACK;
                                r_ack   <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Raw cart_nCS low steals the pins back immediately, before the synchroniser sees it.
    assign w_host_phase = (r_state == S_SETUP) | (r_state == S_STROBE) | (r_state == S_HOLD);
    assign w_owner_host = w_host_phase & bus.cart_nCS;
    assign w_cart_nce   = ~(bus.cart_ram_sel & ~bus.cart_nCS);

    always_comb begin
        w_sram_a = {bus.cart_bank, bus.cart_a};
        w_nce    = w_cart_nce;
        w_noe    = w_cart_nce | bus.cart_nRD;
        w_nwe    = w_cart_nce | bus.cart_nWR | ~bus.cart_wren;
        w_dq_o   = bus.cart_wdata;
        w_dq_oe  = ~w_nce & ~w_nwe;
        if (w_owner_host) begin
            w_sram_a = r_addr;
            w_nce    = 1'b0;
            if (r_we) begin
                w_noe   = 1'b1;
                w_nwe   = (r_state != S_STROBE);
                w_dq_o  = r_wdata;
                w_dq_oe = 1'b1;
            end else begin
                w_noe   = (r_state == S_HOLD);
                w_nwe   = 1'b1;
                w_dq_oe = 1'b0;
            end
        end
    end

    assign bus.sram_a      = w_sram_a;
    assign bus.sram_nCE    = w_nce;
    assign bus.sram_nOE    = w_noe;
    assign bus.sram_nWE    = w_nwe;
    assign bus.sram_dq_o   = w_dq_o;
    assign bus.sram_dq_oe  = w_dq_oe;
    assign bus.cart_rdata  = (~w_owner_host & ~w_cart_nce & ~bus.cart_nRD) ? bus.sram_dq_i : 8'h00;
    assign bus.host_rdata  = r_rdata;
    assign bus.host_ack    = r_ack;
    assign bus.host_busy   = r_busy;
    assign bus.abort_count = r_abort_cnt;
endmodule

// File: tb/tb_cart_sram_arbiter.sv
// Bench for cart_sram_arbiter: SRAM array model, a per-cycle reference model
// of pin ownership/host progress, and directed scenarios with literal checks.
module tb_cart_sram_arbiter;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int IDLE_GAP   = 4;
    localparam int OWN_LEN    = SETUP_CYC + STROBE_CYC + HOLD_CYC;

    logic sys_clock  = 1'b0;
    logic sys_resetn = 1'b0;
    always #5 sys_clock = ~sys_clock;

    cart_sram_arbiter_if bus();

    cart_sram_arbiter #(
        .SYNC_STAGES(2), .IDLE_GAP(IDLE_GAP), .SETUP_CYC(SETUP_CYC),
        .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .sys_clock (sys_clock),
        .sys_resetn(sys_resetn),
        .bus       (bus)
    );

    logic [7:0] mem [0:131071];
    assign bus.sram_dq_i = (!bus.sram_nCE && !bus.sram_nOE) ? mem[bus.sram_a] : 8'hEE;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase = cycles into the current host access (0 = none).
    int          m_phase, m_quiet, m_abort, ack_cnt, nwe_lo_cnt;
    logic        m_pend, m_we, mem_ready;
    logic [16:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic [1:0]  m_pipe;
    logic        hostmode, e_strobe, e_nce, e_noe, e_nwe, e_oe, bs, raw;
    logic [16:0] e_a;
    logic [7:0]  e_dq, e_crd;

    initial begin
        mem_ready = 1'b0; ack_cnt = 0; nwe_lo_cnt = 0;
    end

    always @(negedge sys_clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
            mem_ready = 1'b1;
        end
        if (!sys_resetn) begin
            m_phase = 0; m_pend = 1'b0; m_abort = 0; m_rdata = 8'h00;
            m_quiet = 0; m_pipe = 2'b00;
        end

        hostmode = (m_phase >= 1) && (m_phase <= OWN_LEN) && bus.cart_nCS;
        if (hostmode) begin
            e_a      = m_addr;
            e_nce    = 1'b0;
            e_strobe = (m_phase > SETUP_CYC) && (m_phase <= SETUP_CYC + STROBE_CYC);
            e_dq     = m_wdata;
            if (m_we) begin
                e_noe = 1'b1; e_nwe = !e_strobe; e_oe = 1'b1;
            end else begin
                e_noe = (m_phase > SETUP_CYC + STROBE_CYC); e_nwe = 1'b1; e_oe = 1'b0;
            end
            e_crd = 8'h00;
        end else begin
            e_a   = {bus.cart_bank, bus.cart_a};
            e_nce = !(bus.cart_ram_sel && !bus.cart_nCS);
            e_noe = e_nce || bus.cart_nRD;
            e_nwe = e_nce || bus.cart_nWR || !bus.cart_wren;
            e_oe  = !e_nce && !e_nwe;
            e_dq  = bus.cart_wdata;
            e_crd = (!e_nce && !bus.cart_nRD) ? mem[e_a] : 8'h00;
        end
        chk("sram_a",      32'(bus.sram_a),      32'(e_a));
        chk("sram_nCE",    32'(bus.sram_nCE),    32'(e_nce));
        chk("sram_nOE",    32'(bus.sram_nOE),    32'(e_noe));
        chk("sram_nWE",    32'(bus.sram_nWE),    32'(e_nwe));
        chk("sram_dq_oe",  32'(bus.sram_dq_oe),  32'(e_oe));
        if (e_oe || !hostmode)
            chk("sram_dq_o", 32'(bus.sram_dq_o), 32'(e_dq));
        chk("cart_rdata",  32'(bus.cart_rdata),  32'(e_crd));
        chk("host_ack",    32'(bus.host_ack),    32'(m_phase == OWN_LEN + 1));
        chk("host_busy",   32'(bus.host_busy),   32'(m_pend));
        chk("host_rdata",  32'(bus.host_rdata),  32'(m_rdata));
        chk("abort_count", 32'(bus.abort_count), 32'(m_abort));

        if (bus.host_ack) ack_cnt++;
        if (!bus.sram_nWE) nwe_lo_cnt++;

        if (sys_resetn) begin
            bs  = m_pipe[1];
            raw = !bus.cart_nCS || !bus.cart_nRD || !bus.cart_nWR;
            if (m_phase >= 1 && m_phase <= OWN_LEN && bs) begin
                m_phase = 0;
                if (m_abort < 255) m_abort++;
            end else if (m_phase == 0) begin
                if ((bus.host_req || m_pend) && m_quiet >= IDLE_GAP && !bs) begin
                    if (!m_pend) begin
                        m_addr = bus.host_addr; m_we = bus.host_we; m_wdata = bus.host_wdata;
                    end
                    m_pend  = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == OWN_LEN + 1) begin
                m_phase = 0;
            end else begin
                if (m_phase == SETUP_CYC + STROBE_CYC && !m_we) m_rdata = mem[m_addr];
                m_phase++;
                if (m_phase == OWN_LEN + 1) m_pend = 1'b0;
            end
            m_quiet = bs ? 0 : m_quiet + 1;
            m_pipe  = {m_pipe[0], raw};
        end

        if (!bus.sram_nCE && !bus.sram_nWE && bus.sram_dq_oe)
            mem[bus.sram_a] = bus.sram_dq_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic wait_busy(output int rise);
        rise = -1;
        for (int i = 0; i < 100 && rise < 0; i++) begin
            tick(1);
            if (bus.host_busy) rise = cyc;
        end
        chk("busy_seen", 32'(rise >= 0), 32'd1);
    endtask

    task automatic wait_ack(output int rise, output int ackc, output logic [7:0] rd);
        rise = -1; ackc = -1; rd = 8'h00;
        for (int i = 0; i < 300 && ackc < 0; i++) begin
            tick(1);
            if (bus.host_busy && rise < 0) rise = cyc;
            if (bus.host_ack) begin
                ackc = cyc; rd = bus.host_rdata; bus.host_req = 1'b0;
            end
        end
        chk("ack_seen", 32'(ackc >= 0), 32'd1);
    endtask

    task automatic host_op(input logic we, input logic [16:0] a, input logic [7:0] d,
                           output int rise, output int ackc, output logic [7:0] rd);
        bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_req = 1'b1;
        wait_ack(rise, ackc, rd);
    endtask

    task automatic cart_write(input logic [3:0] bank, input logic [12:0] a, input logic [7:0] d);
        bus.cart_ram_sel = 1'b1; bus.cart_bank = bank; bus.cart_a = a; bus.cart_wdata = d;
        bus.cart_nCS = 1'b0; bus.cart_nWR = 1'b0;
        tick(2);
        bus.cart_nCS = 1'b1; bus.cart_nWR = 1'b1; bus.cart_ram_sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, ackc, rel, s_nwe, s_ack;
        logic [7:0] rd;
        bus.cart_ram_sel = 1'b0; bus.cart_bank = 4'h0; bus.cart_a = 13'h0;
        bus.cart_nCS = 1'b1; bus.cart_nRD = 1'b1; bus.cart_nWR = 1'b1;
        bus.cart_wren = 1'b0; bus.cart_wdata = 8'h00;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00;
        tick(3);
        chk("rst_busy",  32'(bus.host_busy),   32'd0);
        chk("rst_ack",   32'(bus.host_ack),    32'd0);
        chk("rst_rdata", 32'(bus.host_rdata),  32'd0);
        chk("rst_nCE",   32'(bus.sram_nCE),    32'd1);
        sys_resetn = 1'b1;
        tick(6);

        // host write, uncontested
        s_nwe = nwe_lo_cnt; s_ack = ack_cnt;
        host_op(1'b1, 17'h1ABCD, 8'h5A, rise, ackc, rd);
        tick(2);
        chk("t1_latency", 32'(ackc - (rise - 1)), 32'd5);
        chk("t1_nwe_cycles", 32'(nwe_lo_cnt - s_nwe), 32'd2);
        chk("t1_acks", 32'(ack_cnt - s_ack), 32'd1);
        chk("t1_mem", 32'(mem[17'h1ABCD]), 32'h5A);

        // host read back
        s_nwe = nwe_lo_cnt;
        host_op(1'b0, 17'h1ABCD, 8'h00, rise, ackc, rd);
        tick(2);
        chk("t2_rdata", 32'(rd), 32'h5A);
        chk("t2_nwe_cycles", 32'(nwe_lo_cnt - s_nwe), 32'd0);

        // cart read with a pending host request
        bus.cart_wren = 1'b1;
        cart_write(4'h3, 13'h0123, 8'hC3);
        bus.cart_wren = 1'b0;
        tick(6);
        bus.cart_ram_sel = 1'b1; bus.cart_bank = 4'h3; bus.cart_a = 13'h0123;
        bus.cart_nCS = 1'b0; bus.cart_nRD = 1'b0;
        tick(3);
        bus.host_we = 1'b0; bus.host_addr = 17'h06123; bus.host_req = 1'b1;
        tick(1);
        chk("t3_sram_a", 32'(bus.sram_a), 32'h06123);
        chk("t3_nOE", 32'(bus.sram_nOE), 32'd0);
        chk("t3_cart_rdata", 32'(bus.cart_rdata), 32'hC3);
        tick(6);
        chk("t3_held_off", 32'(bus.host_busy), 32'd0);
        bus.cart_nCS = 1'b1; bus.cart_nRD = 1'b1; bus.cart_ram_sel = 1'b0;
        rel = cyc;
        wait_busy(rise);
        chk("t3_accept_delay", 32'(rise - rel), 32'd7);
        wait_ack(rise, ackc, rd);
        chk("t3_host_rdata", 32'(rd), 32'hC3);
        tick(6);

        // cart steals the bus during host STROBE
        bus.cart_bank = 4'h2; bus.cart_a = 13'h0055;
        s_ack = ack_cnt;
        bus.host_we = 1'b1; bus.host_addr = 17'h01234; bus.host_wdata = 8'hA7; bus.host_req = 1'b1;
        wait_busy(rise);
        tick(1);
        bus.cart_nCS = 1'b0;
        #1;
        chk("t4_ovr_a", 32'(bus.sram_a), 32'h04055);
        chk("t4_ovr_nCE", 32'(bus.sram_nCE), 32'd1);
        chk("t4_ovr_oe", 32'(bus.sram_dq_oe), 32'd0);
        tick(3);
        bus.cart_nCS = 1'b1;
        wait_ack(rise, ackc, rd);
        tick(2);
        chk("t4_abort_count", 32'(bus.abort_count), 32'd1);
        chk("t4_acks", 32'(ack_cnt - s_ack), 32'd1);
        chk("t4_mem", 32'(mem[17'h01234]), 32'hA7);

        // cart write gated by cart_wren
        s_nwe = nwe_lo_cnt;
        cart_write(4'h0, 13'h0000, 8'h77);
        tick(2);
        chk("t5_mem_locked", 32'(mem[17'h00000]), 32'h00);
        chk("t5_nwe_locked", 32'(nwe_lo_cnt - s_nwe), 32'd0);
        bus.cart_wren = 1'b1;
        cart_write(4'h0, 13'h0000, 8'h77);
        tick(2);
        chk("t5_mem_written", 32'(mem[17'h00000]), 32'h77);
        chk("t5_nwe_written", 32'(nwe_lo_cnt - s_nwe), 32'd2);
        tick(6);

        // reset during SETUP
        s_ack = ack_cnt;
        bus.host_we = 1'b1; bus.host_addr = 17'h00555; bus.host_wdata = 8'h3C; bus.host_req = 1'b1;
        wait_busy(rise);
        sys_resetn = 1'b0;
        bus.host_req = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.host_busy), 32'd0);
        chk("t6_ack", 32'(bus.host_ack), 32'd0);
        chk("t6_abort", 32'(bus.abort_count), 32'd0);
        chk("t6_rdata", 32'(bus.host_rdata), 32'd0);
        chk("t6_nCE", 32'(bus.sram_nCE), 32'd1);
        tick(2);
        sys_resetn = 1'b1;
        tick(10);
        chk("t6_no_ack", 32'(ack_cnt - s_ack), 32'd0);
        chk("t6_mem_untouched", 32'(mem[17'h00555]), 32'h00);
        host_op(1'b1, 17'h00555, 8'h3C, rise, ackc, rd);
        tick(2);
        chk("t6_mem_after", 32'(mem[17'h00555]), 32'h3C);
        host_op(1'b0, 17'h00555, 8'h00, rise, ackc, rd);
        tick(2);
        chk("t6_readback", 32'(rd), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
